mem_ss_cal_monitor: RTL and testbench

- Per-channel EMIF calibration monitor that sits directly upstream of the memory subsystem CSR block and drives its cal_success/cal_fail status inputs.
- Synchronizes the raw EMIF calibration flags and debounces them.
- Runs one calibration-tracking FSM per channel, with a calibration timeout.
- Also produces aggregate readiness for the memory subsystem top.

---
 rtl/mem_ss_pkg.sv | 15 +
 rtl/mem_ss_cal_chan.sv | 143 ++++++++++++++
 rtl/mem_ss_cal_monitor.sv | 49 ++++
 tb/tb_mem_ss_cal_monitor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_ss_pkg.sv
// Shared memory-subsystem definitions: channel count, calibration monitor
// defaults and the per-channel calibration state encoding.
package mem_ss_pkg;

  localparam int          DDR_CHANNEL                = 4;
  localparam int          CAL_STABLE_CYCLES_DEFAULT  = 16;
  localparam logic [31:0] CAL_TIMEOUT_CYCLES_DEFAULT = 32'd50_000_000;

  typedef enum logic [1:0] {
    CAL_WAIT = 2'd0,
    CAL_PASS = 2'd1,
    CAL_FAIL = 2'd2
  } e_cal_state;

endpackage

// File: rtl/mem_ss_cal_chan.sv
// One EMIF calibration channel: 2-flop synchronizers, per-flag debounce
// counters, saturating WAIT timeout counter, WAIT/PASS/FAIL tracker and
// the sticky timeout / lost indications.
module mem_ss_cal_chan
  import mem_ss_pkg::*;
#(
  parameter int          STABLE_CYCLES  = CAL_STABLE_CYCLES_DEFAULT,
  parameter logic [31:0] TIMEOUT_CYCLES = CAL_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic emif_cal_success,
  input  logic emif_cal_fail,
  input  logic recal_req,
  output logic cal_success,
  output logic cal_fail,
  output logic cal_timeout,
  output logic cal_lost
);

  localparam logic [7:0]  STABLE_LAST  = 8'(STABLE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

  logic [1:0]  succ_sync;
  logic [1:0]  fail_sync;
  logic        s_succ;
  logic        s_fail;
  e_cal_state  state;
  e_cal_state  state_next;
  logic [7:0]  succ_cnt;
  logic [7:0]  fail_cnt;
  logic [31:0] tmo_cnt;
  logic        succ_target;
  logic        succ_on_target;
  logic        succ_accept;
  logic        fail_accept;
  logic        timeout_hit;
  logic        set_timeout;
  logic        set_lost;
  logic        clear_cnt;

  assign s_succ = succ_sync[1];
  assign s_fail = fail_sync[1];

  // Success is awaited high in WAIT and watched for loss (low) in PASS;
  // fail is always awaited high. Nothing is debounced once in FAIL.
  assign succ_target    = (state == CAL_WAIT);
  assign succ_on_target = (s_succ == succ_target);
  assign succ_accept    = (state != CAL_FAIL) && succ_on_target && (succ_cnt == STABLE_LAST);
  assign fail_accept    = (state != CAL_FAIL) && s_fail && (fail_cnt == STABLE_LAST);
  assign timeout_hit    = (state == CAL_WAIT) && (tmo_cnt == TIMEOUT_LAST);
  assign clear_cnt      = recal_req || (state_next != state);

  // Two-flop synchronizers for the asynchronous EMIF flags.
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking (<=) so every stage samples its pre-edge value.
    if (!rst_n) begin
      succ_sync <= '0;
      fail_sync <= '0;
    end else begin
      succ_sync <= {succ_sync[0], emif_cal_success};
      fail_sync <= {fail_sync[0], emif_cal_fail};
    end
  end

  // Next-state logic: recal wins, then fail over success over timeout.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_next  = state;
    set_timeout = 1'b0;
    set_lost    = 1'b0;
    if (recal_req) begin
      state_next = CAL_WAIT;
    end else begin
      case (state)
        CAL_WAIT: begin
          if (fail_accept) begin
            state_next = CAL_FAIL;
          end else if (succ_accept && !s_fail) begin
            state_next = CAL_PASS;
          end else if (timeout_hit) begin
            state_next  = CAL_FAIL;
            set_timeout = 1'b1;
          end
        end
        CAL_PASS: begin
          if (fail_accept) begin
            state_next = CAL_FAIL;
          end else if (succ_accept) begin
            state_next = CAL_WAIT;
            set_lost   = 1'b1;
          end
        end
        CAL_FAIL: state_next = CAL_FAIL;
        default:  state_next = CAL_WAIT;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= CAL_WAIT;
    else        state <= state_next;
  end

  // Debounce counters hold at the accept value so acceptance stays live
  // while a higher-priority condition blocks the transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      succ_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      if (clear_cnt || (state == CAL_FAIL) || !succ_on_target) succ_cnt <= '0;
      else if (succ_cnt != STABLE_LAST)                         succ_cnt <= succ_cnt + 8'd1;

      if (clear_cnt || (state == CAL_FAIL) || !s_fail) fail_cnt <= '0;
      else if (fail_cnt != STABLE_LAST)                 fail_cnt <= fail_cnt + 8'd1;
    end
  end

  // Saturating timeout counter, running only while in WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n)                              tmo_cnt <= '0;
    else if (recal_req || state != CAL_WAIT) tmo_cnt <= '0;
    else if (tmo_cnt != '1)                  tmo_cnt <= tmo_cnt + 32'd1;
  end

  // Registered status outputs and sticky flags; recal clears them at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cal_success <= 1'b0;
      cal_fail    <= 1'b0;
      cal_timeout <= 1'b0;
      cal_lost    <= 1'b0;
    end else begin
      cal_success <= !recal_req && (state == CAL_PASS);
      cal_fail    <= !recal_req && (state == CAL_FAIL);
      cal_timeout <= !recal_req && (cal_timeout || set_timeout);
      cal_lost    <= !recal_req && (cal_lost || set_lost);
    end
  end

endmodule

// File: rtl/mem_ss_cal_monitor.sv
// EMIF calibration monitor: one tracker per channel plus aggregate
// readiness, registered from the per-channel status outputs.
module mem_ss_cal_monitor #(
  parameter int          DDR_CHANNEL    = mem_ss_pkg::DDR_CHANNEL,
  parameter int          STABLE_CYCLES  = mem_ss_pkg::CAL_STABLE_CYCLES_DEFAULT,
  parameter logic [31:0] TIMEOUT_CYCLES = mem_ss_pkg::CAL_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DDR_CHANNEL-1:0] emif_cal_success,
  input  logic [DDR_CHANNEL-1:0] emif_cal_fail,
  input  logic [DDR_CHANNEL-1:0] recal_req,
  output logic [DDR_CHANNEL-1:0] cal_success,
  output logic [DDR_CHANNEL-1:0] cal_fail,
  output logic [DDR_CHANNEL-1:0] cal_timeout,
  output logic [DDR_CHANNEL-1:0] cal_lost,
  output logic                   cal_done,
  output logic                   mem_ready
);

  for (genvar i = 0; i < DDR_CHANNEL; i++) begin : g_chan
    mem_ss_cal_chan #(
      .STABLE_CYCLES  (STABLE_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_chan (
      .clk              (clk),
      .rst_n            (rst_n),
      .emif_cal_success (emif_cal_success[i]),
      .emif_cal_fail    (emif_cal_fail[i]),
      .recal_req        (recal_req[i]),
      .cal_success      (cal_success[i]),
      .cal_fail         (cal_fail[i]),
      .cal_timeout      (cal_timeout[i]),
      .cal_lost         (cal_lost[i])
    );
  end

  // Aggregates: done when no channel is waiting, ready when all passed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cal_done  <= 1'b0;
      mem_ready <= 1'b0;
    end else begin
      cal_done  <= &(cal_success | cal_fail);
      mem_ready <= &cal_success;
    end
  end

endmodule

// File: tb/tb_mem_ss_cal_monitor.sv
// Directed bench for mem_ss_cal_monitor (2 channels, 4-cycle debounce,
// 100-cycle timeout): a vector table plus hand-written corner sequences.
module tb_mem_ss_cal_monitor;

  localparam int N = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] emif_cal_success;
  logic [N-1:0] emif_cal_fail;
  logic [N-1:0] recal_req;
  logic [N-1:0] cal_success;
  logic [N-1:0] cal_fail;
  logic [N-1:0] cal_timeout;
  logic [N-1:0] cal_lost;
  logic         cal_done;
  logic         mem_ready;

  int errors = 0;
  int checks = 0;

  mem_ss_cal_monitor #(
    .DDR_CHANNEL    (N),
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (32'd100)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .emif_cal_success (emif_cal_success),
    .emif_cal_fail    (emif_cal_fail),
    .recal_req        (recal_req),
    .cal_success      (cal_success),
    .cal_fail         (cal_fail),
    .cal_timeout      (cal_timeout),
    .cal_lost         (cal_lost),
    .cal_done         (cal_done),
    .mem_ready        (mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string    name;
    logic     rst;
    logic [1:0] succ;
    logic [1:0] fail;
    logic [1:0] recal;
    int       ticks;
    logic [1:0] e_succ;
    logic [1:0] e_fail;
    logic [1:0] e_tmo;
    logic [1:0] e_lost;
    logic     e_done;
    logic     e_rdy;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(string n, logic r, logic [1:0] s, logic [1:0] f,
                              logic [1:0] q, int t, logic [1:0] es, logic [1:0] ef,
                              logic [1:0] et, logic [1:0] el, logic ed, logic er);
    vec_t v;
    v.name = n; v.rst = r; v.succ = s; v.fail = f; v.recal = q; v.ticks = t;
    v.e_succ = es; v.e_fail = ef; v.e_tmo = et; v.e_lost = el; v.e_done = ed; v.e_rdy = er;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic [1:0] es, logic [1:0] ef, logic [1:0] et,
                            logic [1:0] el, logic ed, logic er);
    check({tag, ".cal_success"}, 32'(cal_success), 32'(es));
    check({tag, ".cal_fail"},    32'(cal_fail),    32'(ef));
    check({tag, ".cal_timeout"}, 32'(cal_timeout), 32'(et));
    check({tag, ".cal_lost"},    32'(cal_lost),    32'(el));
    check({tag, ".cal_done"},    32'(cal_done),    32'(ed));
    check({tag, ".mem_ready"},   32'(mem_ready),   32'(er));
  endtask

  task automatic do_reset(logic [1:0] s, logic [1:0] f);
    rst_n = 1'b0; emif_cal_success = s; emif_cal_fail = f; recal_req = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; emif_cal_success = '0; emif_cal_fail = '0; recal_req = '0;

    //              name             rst succ   fail   recal  t   e_succ e_fail e_tmo  e_lost done rdy
    vecs[0]  = mk("reset",          0, 2'b00, 2'b00, 2'b00, 2, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    vecs[1]  = mk("idle",           1, 2'b00, 2'b00, 2'b00, 10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    vecs[2]  = mk("succ_pre",       1, 2'b11, 2'b00, 2'b00, 6, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    vecs[3]  = mk("succ_out",       1, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    vecs[4]  = mk("ready",          1, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1);
    vecs[5]  = mk("pass_fail_pre",  1, 2'b11, 2'b10, 2'b00, 6, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1);
    vecs[6]  = mk("pass_to_fail",   1, 2'b11, 2'b10, 2'b00, 1, 2'b01, 2'b10, 2'b00, 2'b00, 1, 1);
    vecs[7]  = mk("ready_drop",     1, 2'b11, 2'b10, 2'b00, 1, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0);
    vecs[8]  = mk("fail_terminal",  1, 2'b11, 2'b00, 2'b00, 10, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0);
    vecs[9]  = mk("recal_ch1",      1, 2'b11, 2'b00, 2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0);
    vecs[10] = mk("recal_done_lag", 1, 2'b11, 2'b00, 2'b00, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
    vecs[11] = mk("reaccept_pre",   1, 2'b11, 2'b00, 2'b00, 3, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
    vecs[12] = mk("reaccept",       1, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    vecs[13] = mk("ready_again",    1, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1);
    vecs[14] = mk("rst_mid",        0, 2'b11, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    vecs[15] = mk("rst_pre",        1, 2'b11, 2'b00, 2'b00, 6, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    vecs[16] = mk("rst_reaccept",   1, 2'b11, 2'b00, 2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    vecs[17] = mk("rst_both",       0, 2'b11, 2'b10, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    vecs[18] = mk("both_pre",       1, 2'b11, 2'b10, 2'b00, 6, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    vecs[19] = mk("fail_prio",      1, 2'b11, 2'b10, 2'b00, 1, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0);
    vecs[20] = mk("fail_prio_done", 1, 2'b11, 2'b10, 2'b00, 1, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0);
    vecs[21] = mk("glitch_low",     1, 2'b10, 2'b10, 2'b00, 3, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0);
    vecs[22] = mk("glitch_hold",    1, 2'b11, 2'b10, 2'b00, 10, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0);
    vecs[23] = mk("drop_pre",       1, 2'b10, 2'b10, 2'b00, 4, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0);
    vecs[24] = mk("drop_lost",      1, 2'b10, 2'b10, 2'b00, 2, 2'b01, 2'b10, 2'b00, 2'b01, 1, 0);
    vecs[25] = mk("drop_out",       1, 2'b10, 2'b10, 2'b00, 1, 2'b00, 2'b10, 2'b00, 2'b01, 1, 0);
    vecs[26] = mk("drop_done",      1, 2'b10, 2'b10, 2'b00, 1, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
    vecs[27] = mk("restore_pre",    1, 2'b11, 2'b10, 2'b00, 6, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
    vecs[28] = mk("restore",        1, 2'b11, 2'b10, 2'b00, 1, 2'b01, 2'b10, 2'b00, 2'b01, 0, 0);

    // Table: inputs held for 'ticks' edges (recal only on the first), then compare.
    for (int i = 0; i < 29; i++) begin
      rst_n            = vecs[i].rst;
      emif_cal_success = vecs[i].succ;
      emif_cal_fail    = vecs[i].fail;
      recal_req        = vecs[i].recal;
      for (int t = 0; t < vecs[i].ticks; t++) begin
        tick();
        recal_req = '0;
      end
      check_outs(vecs[i].name, vecs[i].e_succ, vecs[i].e_fail, vecs[i].e_tmo,
                 vecs[i].e_lost, vecs[i].e_done, vecs[i].e_rdy);
    end

    // Timeout on ch0; ch1 success is accepted in the very cycle its own
    // timeout would fire, so acceptance must win there.
    do_reset(2'b00, 2'b00);
    for (int t = 0; t < 94; t++) tick();
    emif_cal_success = 2'b10;
    for (int t = 0; t < 5; t++) tick();
    check_outs("tmo_before", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    tick();
    check_outs("tmo_set", 2'b00, 2'b00, 2'b01, 2'b00, 0, 0);
    tick();
    check_outs("tmo_fail", 2'b10, 2'b01, 2'b01, 2'b00, 0, 0);
    tick();
    check_outs("tmo_done", 2'b10, 2'b01, 2'b01, 2'b00, 1, 0);
    recal_req = 2'b01;
    tick();
    recal_req = 2'b00;
    check_outs("tmo_recal", 2'b10, 2'b00, 2'b00, 2'b00, 1, 0);
    tick();
    check_outs("tmo_recal_lag", 2'b10, 2'b00, 2'b00, 2'b00, 0, 0);

    // recal on ch0 lands on the edge its success acceptance would take effect.
    do_reset(2'b11, 2'b00);
    for (int t = 0; t < 5; t++) tick();
    recal_req = 2'b01;
    tick();
    recal_req = 2'b00;
    tick();
    check_outs("coll_blocked", 2'b10, 2'b00, 2'b00, 2'b00, 0, 0);
    for (int t = 0; t < 3; t++) tick();
    check_outs("coll_pre", 2'b10, 2'b00, 2'b00, 2'b00, 0, 0);
    tick();
    check_outs("coll_reaccept", 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
    tick();
    check_outs("coll_ready", 2'b11, 2'b00, 2'b00, 2'b00, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
